// File: rtl/sd_cmd_sequencer.sv
// Queued SD command issuer: register-bus command FIFO feeding a start/finish handshake.
// Optional card-detect synchroniser enabled by defining SD_CMDSEQ_DETECT_EN.
module sd_cmd_sequencer #(
  parameter int QDEPTH = 4,
  parameter int RESP_W = 128,
  parameter int TMO_W  = 32
) (
  input  logic              msoc_clk,
  input  logic              rstn,
  input  logic              reg_en,
  input  logic              reg_we,
  input  logic [7:0]        reg_be,
  input  logic [6:0]        reg_addr,
  input  logic [63:0]       reg_wrdata,
  output logic [63:0]       reg_rddata,
  output logic [5:0]        cmd_index_o,
  output logic [2:0]        cmd_setting_o,
  output logic [2:0]        data_start_o,
  output logic [31:0]       cmd_arg_o,
  output logic              start_o,
  input  logic              finish_i,
  input  logic [RESP_W-1:0] resp_i,
  input  logic              crc_ok_i,
  input  logic              index_ok_i,
  input  logic              sd_detect,
  output logic              irq
);
  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [31:0] arg;
    logic [2:0]  dstart;
    logic [2:0]  setting;
    logic [5:0]  index;
  } cmd_t;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RELEASE, S_HALT} state_t;

  state_t            state_q;
  cmd_t              fifo_q [QDEPTH];
  cmd_t              push_cmd;
  logic [PW-1:0]     wptr_q, rptr_q;
  logic [CW-1:0]     cnt_q;
  logic [TMO_W-1:0]  tmo_q, tmo_cnt_q;
  logic [RESP_W-1:0] resp_q;
  logic [127:0]      resp_ext;
  logic              crc_q, idx_q, fail_q, halt_q, flush_q;
  logic [4:0]        irq_stat_q, irq_stat_d, irq_en_q, set_v;
  logic [63:0]       rdata_d;
  logic [3:0]        sel;
  logic              wr, rd, wr_push, wr_stat, wr_en, wr_tmo, wr_ctrl;
  logic              full, empty, pop, push_ok, ovf_set, done_set, err_set, tmo_hit;
  logic              det_set, det_lvl;

  assign sel     = reg_addr[6:3];
  assign wr      = reg_en & reg_we & (|reg_be);
  assign rd      = reg_en & ~reg_we;
  assign wr_push = wr && (sel == 4'd0);
  assign wr_stat = wr && (sel == 4'd2);
  assign wr_en   = wr && (sel == 4'd3);
  assign wr_tmo  = wr && (sel == 4'd6);
  assign wr_ctrl = wr && (sel == 4'd7);

  assign push_cmd = '{arg: reg_wrdata[63:32], dstart: reg_wrdata[11:9],
                      setting: reg_wrdata[8:6], index: reg_wrdata[5:0]};

  // A pending flush owns the FIFO for its cycle: no pop, and pushes are dropped silently.
  assign full    = (cnt_q == CW'(QDEPTH));
  assign empty   = (cnt_q == '0);
  assign pop     = (state_q == S_IDLE) && !empty && !flush_q;
  assign push_ok = wr_push && !flush_q && (!full || pop);
  assign ovf_set = wr_push && !flush_q && full && !pop;

  assign done_set = (state_q == S_ISSUE) && finish_i;
  assign err_set  = done_set && !(crc_ok_i && index_ok_i);
  assign tmo_hit  = (state_q == S_ISSUE) && !finish_i && (tmo_q != '0) && (tmo_cnt_q == tmo_q);

  always_ff @(posedge msoc_clk) begin
    if (push_ok) fifo_q[wptr_q] <= push_cmd;
  end

  always_ff @(posedge msoc_clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (flush_q) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop)     rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_q + CW'(push_ok) - CW'(pop);
    end
  end

  always_ff @(posedge msoc_clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= S_IDLE;
      start_o       <= 1'b0;
      cmd_index_o   <= '0;
      cmd_setting_o <= '0;
      data_start_o  <= '0;
      cmd_arg_o     <= '0;
      tmo_cnt_q     <= '0;
      fail_q        <= 1'b0;
      resp_q        <= '0;
      crc_q         <= 1'b0;
      idx_q         <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (pop) begin
          cmd_index_o   <= fifo_q[rptr_q].index;
          cmd_setting_o <= fifo_q[rptr_q].setting;
          data_start_o  <= fifo_q[rptr_q].dstart;
          cmd_arg_o     <= fifo_q[rptr_q].arg;
          tmo_cnt_q     <= '0;
          fail_q        <= 1'b0;
          start_o       <= 1'b1;
          state_q       <= S_ISSUE;
        end
        S_ISSUE: begin
          if (finish_i) begin
            resp_q  <= resp_i;
            crc_q   <= crc_ok_i;
            idx_q   <= index_ok_i;
            fail_q  <= !(crc_ok_i && index_ok_i);
            start_o <= 1'b0;
            state_q <= S_RELEASE;
          end else if (tmo_hit) begin
            fail_q  <= 1'b1;
            start_o <= 1'b0;
            state_q <= S_RELEASE;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
        end
        S_RELEASE: if (!finish_i) state_q <= (fail_q && halt_q) ? S_HALT : S_IDLE;
        S_HALT:    if (flush_q || !halt_q) state_q <= S_IDLE;
        default:   state_q <= S_IDLE;
      endcase
    end
  end

  // Hardware set beats a same-cycle W1C.
  assign set_v      = {err_set, det_set, ovf_set, tmo_hit, done_set};
  assign irq_stat_d = (irq_stat_q & ~(wr_stat ? reg_wrdata[4:0] : 5'd0)) | set_v;

  always_ff @(posedge msoc_clk or negedge rstn) begin
    if (!rstn) begin
      irq_stat_q <= '0;
      irq_en_q   <= '0;
      tmo_q      <= '0;
      halt_q     <= 1'b0;
      flush_q    <= 1'b0;
      irq        <= 1'b0;
    end else begin
      irq_stat_q <= irq_stat_d;
      if (wr_en)   irq_en_q <= reg_wrdata[4:0];
      if (wr_tmo)  tmo_q    <= reg_wrdata[TMO_W-1:0];
      if (wr_ctrl) halt_q   <= reg_wrdata[1];
      flush_q <= wr_ctrl & reg_wrdata[0];
      irq     <= |(irq_stat_q & irq_en_q);
    end
  end

`ifdef SD_CMDSEQ_DETECT_EN
  logic det_s1_q, det_s2_q, det_h_q;
  logic unused_bits;
  assign unused_bits = ^{reg_addr[2:0], reg_wrdata};

  always_ff @(posedge msoc_clk or negedge rstn) begin
    if (!rstn) {det_h_q, det_s2_q, det_s1_q} <= 3'b000;
    else       {det_h_q, det_s2_q, det_s1_q} <= {det_s2_q, det_s1_q, sd_detect};
  end

  assign det_set = det_s2_q ^ det_h_q;
  assign det_lvl = det_s2_q;
`else
  logic unused_bits;
  assign unused_bits = ^{reg_addr[2:0], reg_wrdata, sd_detect};
  assign det_set = 1'b0;
  assign det_lvl = 1'b0;
`endif

  assign resp_ext = 128'(resp_q);

  always_comb begin
    rdata_d = 64'hDEADBEEF;
    case (sel)
      4'd0: rdata_d = 64'h0;
      4'd1: rdata_d = {45'd0, det_lvl, idx_q, crc_q, 8'(cnt_q), 4'd0,
                       state_q == S_HALT, full, empty, state_q != S_IDLE};
      4'd2: rdata_d = {59'd0, irq_stat_q};
      4'd3: rdata_d = {59'd0, irq_en_q};
      4'd4: rdata_d = resp_ext[63:0];
      4'd5: rdata_d = resp_ext[127:64];
      4'd6: rdata_d = 64'(tmo_q);
      4'd7: rdata_d = {62'd0, halt_q, 1'b0};
      default: rdata_d = 64'hDEADBEEF;
    endcase
  end

  always_ff @(posedge msoc_clk or negedge rstn) begin
    if (!rstn)   reg_rddata <= '0;
    else if (rd) reg_rddata <= rdata_d;
  end
endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// Scoreboard bench for sd_cmd_sequencer: expected issues and register reads are queued
// by the stimulus and checked by independent monitors; a behavioural core answers handshakes.
`timescale 1ns/1ps
module tb_sd_cmd_sequencer;
  logic         msoc_clk = 1'b0, rstn = 1'b0;
  logic         reg_en = 1'b0, reg_we = 1'b0;
  logic [7:0]   reg_be = 8'h00;
  logic [6:0]   reg_addr = 7'd0;
  logic [63:0]  reg_wrdata = 64'd0, reg_rddata;
  logic [5:0]   cmd_index_o;
  logic [2:0]   cmd_setting_o, data_start_o;
  logic [31:0]  cmd_arg_o;
  logic         start_o, finish_i, irq;
  logic [127:0] resp_i = 128'd0;
  logic         crc_ok_i = 1'b0, index_ok_i = 1'b0, sd_detect = 1'b0;
  logic         fin_r = 1'b0, fin_m = 1'b0;

  assign finish_i = fin_r | fin_m;
  always #5 msoc_clk = ~msoc_clk;

  sd_cmd_sequencer dut (
    .msoc_clk(msoc_clk), .rstn(rstn), .reg_en(reg_en), .reg_we(reg_we), .reg_be(reg_be),
    .reg_addr(reg_addr), .reg_wrdata(reg_wrdata), .reg_rddata(reg_rddata),
    .cmd_index_o(cmd_index_o), .cmd_setting_o(cmd_setting_o), .data_start_o(data_start_o),
    .cmd_arg_o(cmd_arg_o), .start_o(start_o), .finish_i(finish_i), .resp_i(resp_i),
    .crc_ok_i(crc_ok_i), .index_ok_i(index_ok_i), .sd_detect(sd_detect), .irq(irq)
  );

  localparam logic [63:0] ALL = '1;
  int n_chk = 0, n_fail = 0;
  int cyc = 0, push_cyc = 0;
  always @(posedge msoc_clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endfunction

  // Register read scoreboard: expected value/mask pushed by rd(), checked when data returns.
  logic [63:0] rq_exp[$], rq_msk[$];
  string       rq_nm[$];
  logic        rd_pend = 1'b0;
  always @(posedge msoc_clk) rd_pend <= reg_en & ~reg_we;

  initial forever begin
    @(negedge msoc_clk);
    if (rd_pend) begin
      if (rq_exp.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL rd_unexpected: got %h want no read", reg_rddata);
      end else begin
        logic [63:0] e, m;
        string nm;
        e = rq_exp.pop_front(); m = rq_msk.pop_front(); nm = rq_nm.pop_front();
        chk(nm, reg_rddata & m, e & m);
      end
    end
  end

  // Issue monitor: every rising start_o must match the next queued command.
  logic [43:0] exp_cmd[$];
  logic        st_prev = 1'b0;
  int          hi_len = 0, last_len = 0;

  initial forever begin
    @(negedge msoc_clk);
    if (start_o && !st_prev) begin
      hi_len = 0;
      if (exp_cmd.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL issue_unexpected: got idx %0d arg %h want none", cmd_index_o, cmd_arg_o);
      end else begin
        chk("issue_cmd", 64'({cmd_arg_o, data_start_o, cmd_setting_o, cmd_index_o}),
            64'(exp_cmd.pop_front()));
      end
    end
    if (start_o) hi_len++;
    if (!start_o && st_prev) last_len = hi_len;
    st_prev = start_o;
  end

  // Behavioural core: raise finish r_delay cycles into start_o, release once start_o drops.
  int           r_delay = -1, r_cnt = 0;
  bit           r_rand = 1'b0, r_crc = 1'b1, r_idx = 1'b1;
  logic [127:0] r_resp = 128'd0, m_resp = 128'd0;
  bit           m_crc = 1'b0, m_idx = 1'b0, m_err = 1'b0;
  int           m_done = 0;

  initial forever begin
    @(negedge msoc_clk);
    if (fin_r) begin
      chk("fin2drop", start_o, 1'b0);
      fin_r = 1'b0;
      r_cnt = 0;
    end else if (start_o) begin
      if (r_cnt == 0 && r_rand) begin
        r_delay = $urandom_range(0, 6);
        r_resp  = {$urandom, $urandom, $urandom, $urandom};
        r_crc   = ($urandom_range(0, 3) != 0);
        r_idx   = ($urandom_range(0, 3) != 0);
      end
      if (r_delay >= 0 && r_cnt >= r_delay) begin
        fin_r = 1'b1; resp_i = r_resp; crc_ok_i = r_crc; index_ok_i = r_idx;
        m_resp = r_resp; m_crc = r_crc; m_idx = r_idx;
        if (!(r_crc && r_idx)) m_err = 1'b1;
        m_done++;
      end
      r_cnt++;
    end else begin
      r_cnt = 0;
    end
  end

  // All bus tasks start and end on a negedge, so consecutive calls are back-to-back cycles.
  task automatic wr(input logic [3:0] a, input logic [63:0] d);
    reg_en = 1'b1; reg_we = 1'b1; reg_be = 8'hFF; reg_addr = {a, 3'b000}; reg_wrdata = d;
    @(negedge msoc_clk);
    reg_en = 1'b0; reg_we = 1'b0; reg_be = 8'h00;
  endtask

  task automatic rd(input logic [3:0] a, input logic [63:0] e, input logic [63:0] m, input string nm);
    rq_exp.push_back(e); rq_msk.push_back(m); rq_nm.push_back(nm);
    reg_en = 1'b1; reg_we = 1'b0; reg_addr = {a, 3'b000};
    @(negedge msoc_clk);
    reg_en = 1'b0;
  endtask

  task automatic push(input logic [5:0] idx, input logic [2:0] st, input logic [2:0] ds,
                      input logic [31:0] arg, input bit issued);
    if (issued) exp_cmd.push_back({arg, ds, st, idx});
    wr(4'd0, {arg, 20'd0, ds, st, idx});
    push_cyc = cyc;
  endtask

  task automatic push_rnd(input bit issued);
    push(6'($urandom), 3'($urandom), 3'($urandom), $urandom, issued);
  endtask

  task automatic wait_start(input int bound, input string nm);
    int t = 0;
    while (!start_o && t < bound) begin @(negedge msoc_clk); t++; end
    chk(nm, start_o, 1'b1);
  endtask

  task automatic wait_idle(input int bound, input string nm);
    int q = 0, t = 0;
    while (q < 3 && t < bound) begin
      @(negedge msoc_clk); t++;
      if (!start_o && !finish_i && exp_cmd.size() == 0) q++; else q = 0;
    end
    chk(nm, q >= 3, 1'b1);
  endtask

  int n;

  initial begin
    repeat (3) @(negedge msoc_clk);
    chk("rst_rddata", reg_rddata, 64'd0);
    chk("rst_start", start_o, 1'b0);
    chk("rst_irq", irq, 1'b0);
    chk("rst_cmd", 64'({cmd_arg_o, data_start_o, cmd_setting_o, cmd_index_o}), 64'd0);
    rstn = 1'b1;
    @(negedge msoc_clk);
    rd(4'd1, 64'h2, ALL, "rst_status");
    rd(4'd2, 64'h0, ALL, "rst_irqstat");
    rd(4'd6, 64'h0, ALL, "rst_timeout");
    rd(4'd7, 64'h0, ALL, "rst_ctrl");
    rd(4'd10, 64'hDEADBEEF, ALL, "unmapped");

    // Basic command: start_o appears one edge after the write edge (2 cycles from reg_en).
    r_delay = 5; r_resp = 128'hA5; r_crc = 1'b1; r_idx = 1'b1;
    push(6'd17, 3'd3, 3'd2, 32'h1000, 1'b1);
    wait_start(20, "t1_start");
    chk("push2start", 64'(cyc - push_cyc), 64'd1);
    wait_idle(50, "t1_done");
    rd(4'd4, 64'hA5, ALL, "resp_lo");
    rd(4'd5, 64'h0, ALL, "resp_hi");
    rd(4'd1, 64'h30002, ALL, "t1_status");
    rd(4'd2, 64'h01, ALL, "t1_irq_done");
    wr(4'd2, 64'h1F);

    // Overflow: head goes in flight, four more fill the FIFO, sixth overflows.
    r_delay = -1;
    for (int i = 0; i < 5; i++) push_rnd(1'b1);
    rd(4'd1, 64'h0405, 64'hFFFF, "ovf_count4");
    push_rnd(1'b0);
    rd(4'd2, 64'h04, ALL, "ovf_set");
    chk("irq_masked", irq, 1'b0);
    wr(4'd3, 64'h4);
    @(negedge msoc_clk);
    chk("irq_ovf", irq, 1'b1);
    rd(4'd3, 64'h4, ALL, "irq_en_rb");
    wr(4'd3, 64'h0);
    wr(4'd2, 64'h1F);
    r_delay = 1;
    wait_idle(300, "ovf_drain");
    rd(4'd1, 64'h2, 64'hFFFF, "ovf_drained");
    wr(4'd2, 64'h1F);

    // Timeout: start_o high for TIMEOUT+1 cycles.
    r_delay = -1;
    wr(4'd6, 64'd10);
    rd(4'd6, 64'd10, ALL, "tmo_rb");
    push_rnd(1'b1);
    wait_idle(60, "tmo_done");
    chk("tmo_len", 64'(last_len), 64'd11);
    rd(4'd2, 64'h02, ALL, "tmo_set");
    wr(4'd2, 64'h1F);

    // Halt on error: second command must stay queued until flushed away.
    wr(4'd7, 64'h2);
    push_rnd(1'b1);
    push_rnd(1'b0);
    wait_idle(60, "halt_tmo");
    repeat (10) @(negedge msoc_clk);
    rd(4'd1, 64'h0109, 64'hFFFF, "halted");
    wr(4'd7, 64'h3);
    repeat (3) @(negedge msoc_clk);
    rd(4'd1, 64'h2, 64'hFFFF, "halt_flushed");
    rd(4'd7, 64'h2, ALL, "ctrl_rb");
    wr(4'd7, 64'h0);
    wr(4'd6, 64'h0);
    wr(4'd2, 64'h1F);

    // CRC failure: DONE and ERR; W1C of ERR alone.
    r_delay = 2; r_crc = 1'b0; r_idx = 1'b1;
    r_resp = {$urandom, $urandom, $urandom, $urandom};
    push_rnd(1'b1);
    wait_idle(50, "err_done");
    rd(4'd2, 64'h11, ALL, "err_irq");
    rd(4'd1, 64'h20002, 64'h3FFFF, "err_status");
    rd(4'd4, r_resp[63:0], ALL, "err_resp_lo");
    rd(4'd5, r_resp[127:64], ALL, "err_resp_hi");
    wr(4'd2, 64'h10);
    rd(4'd2, 64'h01, ALL, "w1c_err_only");

    // W1C of DONE on the very edge a new DONE is set: set wins.
    r_delay = -1; r_crc = 1'b1;
    push_rnd(1'b1);
    wait_start(20, "w1c_start");
    repeat (2) @(negedge msoc_clk);
    crc_ok_i = 1'b1; index_ok_i = 1'b1; fin_m = 1'b1;
    reg_en = 1'b1; reg_we = 1'b1; reg_be = 8'hFF; reg_addr = {4'd2, 3'b000}; reg_wrdata = 64'h1;
    @(negedge msoc_clk);
    reg_en = 1'b0; reg_we = 1'b0; reg_be = 8'h00;
    chk("fin2drop_m", start_o, 1'b0);
    fin_m = 1'b0;
    wait_idle(20, "w1c_idle");
    rd(4'd2, 64'h01, ALL, "w1c_vs_set");
    wr(4'd2, 64'h1F);

    // Flush with a same-cycle push while a command is in flight.
    r_delay = -1;
    push_rnd(1'b1);
    wait_start(20, "fl_start");
    push_rnd(1'b0);
    wr(4'd7, 64'h1);
    push_rnd(1'b0);
    repeat (3) @(negedge msoc_clk);
    rd(4'd1, 64'h3, 64'hFFFF, "flush_inflight");
    rd(4'd2, 64'h0, ALL, "flush_no_ovf");
    r_delay = 0;
    wait_idle(50, "flush_done");
    rd(4'd1, 64'h2, 64'hFFFF, "flush_after");
    rd(4'd2, 64'h01, ALL, "flush_irq");
    wr(4'd2, 64'h1F);

    // Random bursts against the behavioural core.
    r_rand = 1'b1;
    for (int b = 0; b < 8; b++) begin
      n = $urandom_range(1, 4);
      m_err = 1'b0; m_done = 0;
      for (int k = 0; k < n; k++) push_rnd(1'b1);
      wait_idle(400, "rnd_drain");
      chk("rnd_count", 64'(m_done), 64'(n));
      rd(4'd4, m_resp[63:0], ALL, "rnd_resp_lo");
      rd(4'd5, m_resp[127:64], ALL, "rnd_resp_hi");
      rd(4'd1, 64'({m_idx, m_crc, 16'h0002}), 64'h3FFFF, "rnd_status");
      rd(4'd2, 64'({m_err, 4'b0001}), ALL, "rnd_irq");
      wr(4'd2, 64'h1F);
    end
    r_rand = 1'b0;

`ifdef SD_CMDSEQ_DETECT_EN
    sd_detect = 1'b1;
    repeat (3) @(negedge msoc_clk);
    rd(4'd2, 64'h08, 64'h08, "det_rise");
    rd(4'd1, 64'h40000, 64'h40000, "det_lvl_hi");
    wr(4'd2, 64'h1F);
    sd_detect = 1'b0;
    repeat (3) @(negedge msoc_clk);
    rd(4'd2, 64'h08, 64'h08, "det_fall");
    rd(4'd1, 64'h0, 64'h40000, "det_lvl_lo");
`else
    sd_detect = 1'b1;
    repeat (6) @(negedge msoc_clk);
    rd(4'd2, 64'h0, 64'h08, "det_off");
    rd(4'd1, 64'h0, 64'h40000, "det_lvl_off");
    sd_detect = 1'b0;
`endif
    repeat (3) @(negedge msoc_clk);
    chk("rd_queue_empty", 64'(rq_exp.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, want finish within 50000 cycles");
    $fatal(1, "watchdog expired");
  end
endmodule
